bch_syndrome_calc: RTL

Serial syndrome generator for the binary BCH decoder over GF(2^13) (primitive polynomial x^13+x^4+x^3+x+1). It consumes one received codeword bit per cycle, highest-degree coefficient first, and evaluates the received polynomial at alpha^1 … alpha^(2T) by Horner's rule. The accumulators use constant GF(2^13) multipliers. The 2T syndromes are presented in a holding register to the key-equation (Euclidean) solver downstream.

---
 rtl/bch_gf_pkg.sv | 46 ++++
 rtl/gf_const_mul.sv | 13 +
 rtl/bch_syndrome_calc.sv | 118 +++++++++++
 3 files changed

// File: rtl/bch_gf_pkg.sv
// GF(2^13) arithmetic helpers for the BCH syndrome datapath.
// All functions use fixed loop bounds so constant arguments fold into XOR networks.
package bch_gf_pkg;

  localparam int              GF_M     = 13;
  localparam logic [GF_M-1:0] GF_POLY  = 13'h001B;
  localparam int unsigned     GF_ORDER = 8191;

  // Multiply by alpha: shift left and reduce modulo the primitive polynomial.
  function automatic logic [GF_M-1:0] gf_xtime(input logic [GF_M-1:0] a);
    return {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? GF_POLY : '0);
  endfunction

  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                             input logic [GF_M-1:0] b);
    logic [GF_M-1:0] p;
    logic [GF_M-1:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) p = p ^ s;
      s = gf_xtime(s);
    end
    return p;
  endfunction

  function automatic logic [GF_M-1:0] gf_alpha_pow(input int unsigned k);
    logic [GF_M-1:0] r;
    logic [GF_M-1:0] base;
    logic [GF_M-1:0] e;
    r    = GF_M'(1);
    base = GF_M'(2);
    e    = GF_M'(k % GF_ORDER);
    for (int i = 0; i < GF_M; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [GF_M-1:0] gf_mul_const(input logic [GF_M-1:0] a,
                                                   input int unsigned k);
    return gf_mul(a, gf_alpha_pow(k));
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(2^13) multiply by the constant alpha^K.
module gf_const_mul
  import bch_gf_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [GF_M-1:0] a,
  output logic [GF_M-1:0] c
);

  assign c = gf_mul_const(a, K);

endmodule

// File: rtl/bch_syndrome_calc.sv
// Serial BCH syndrome generator: Horner evaluation of r(x) at alpha^1..alpha^2T,
// one received bit per cycle, result held in a handshaked output register.
module bch_syndrome_calc
  import bch_gf_pkg::*;
#(
  parameter int M = 13,
  parameter int T = 8,
  parameter int N = 8191
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*T*M-1:0]   out_synd,
  output logic               out_nonzero,
  output logic               out_len_err
);

  localparam int               NS      = 2 * T;
  localparam int               CNT_W   = 13;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);

  logic [M-1:0]      acc_q   [NS];
  logic [M-1:0]      acc_d   [NS];
  logic [M-1:0]      acc_mul [NS];
  logic [NS*M-1:0]   synd_new;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [NS*M-1:0]   out_synd_q, out_synd_d;
  logic              out_nonzero_q, out_nonzero_d;
  logic              out_len_err_q, out_len_err_d;
  logic              xfer;
  logic              out_take;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign out_take = out_valid_q && out_ready;

  // Zeroing after the multiplier is equivalent to zeroing its input (0 * x = 0).
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_synd
      gf_const_mul #(.K(gi + 1)) u_mul (
        .a (acc_q[gi]),
        .c (acc_mul[gi])
      );
      assign synd_new[gi*M +: M] = (first_q ? '0 : acc_mul[gi]) ^ {{(M-1){1'b0}}, in_bit};
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < NS; j++) acc_d[j] = acc_q[j];
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    first_d       = first_q;
    out_valid_d   = out_valid_q;
    out_synd_d    = out_synd_q;
    out_nonzero_d = out_nonzero_q;
    out_len_err_d = out_len_err_q;

    if (xfer) begin
      for (int j = 0; j < NS; j++) acc_d[j] = synd_new[j*M +: M];
      first_d = in_last;
      if (first_q) begin
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        // The sticky overflow keeps saturated overlength words from matching N.
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (xfer && in_last) begin
      out_valid_d   = 1'b1;
      out_synd_d    = synd_new;
      out_nonzero_d = |synd_new;
      out_len_err_d = (cnt_d != N_CNT) || ovf_d;
    end else if (out_take) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NS; j++) acc_q[j] <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      first_q       <= 1'b1;
      out_valid_q   <= 1'b0;
      out_synd_q    <= '0;
      out_nonzero_q <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      for (int j = 0; j < NS; j++) acc_q[j] <= acc_d[j];
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      first_q       <= first_d;
      out_valid_q   <= out_valid_d;
      out_synd_q    <= out_synd_d;
      out_nonzero_q <= out_nonzero_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_synd    = out_synd_q;
  assign out_nonzero = out_nonzero_q;
  assign out_len_err = out_len_err_q;

endmodule
